stim_gen: RTL and testbench

STIM_GEN -- requirements
Module: stim_gen

---
 rtl/stim_gen.sv | 157 +++++++++++++++
 tb/tb_stim_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/stim_gen.sv
`timescale 1ns/1ps
// stim_gen: multi-channel stimulus generator.
//   Three-state controller (IDLE -> RUN -> DONE) presents NUM_CYCLES samples per
//   run on CHANNELS independent lanes of WIDTH bits. The pattern is chosen by the
//   mode latched at start: 0 random (per-lane Galois LFSR), 1 increment,
//   2 walking one, 3 zero.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         run request, only looked at in IDLE
//   mode[1:0]     pattern select, captured when start is accepted
//   hold          stalls the run; only input with a combinational path (to valid)
//   data          CHANNELS*WIDTH bits, lane k at [k*WIDTH +: WIDTH]
//   valid         sample on data is consumed this cycle
//   sample_idx    index of the presented sample
//   busy, done    in RUN / one-cycle end-of-run pulse

// stim_lane: one channel's pattern state. The data register doubles as the
// increment counter and the walking-one shifter, so no per-lane index is kept.
module stim_lane #(
    parameter int          WIDTH = 8,
    parameter int          K     = 0,
    parameter logic [31:0] SEED  = 32'hACE1_2468
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,      // start accepted: reseed and present sample 0
    input  logic             adv,       // sample consumed: step to the next one
    input  logic [1:0]       mode_new,  // mode being latched this cycle
    input  logic [1:0]       mode_cur,  // latched mode of the current run
    output logic [WIDTH-1:0] data
);
    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0]      TAPS  = 32'h8020_0003;
    localparam logic [31:0]      RAW   = SEED ^ (32'(K) * 32'h9E37_79B9);
    localparam logic [31:0]      LSEED = (RAW == 32'd0) ? 32'd1 : RAW;
    localparam logic [WIDTH-1:0] INC0  = WIDTH'(K);
    localparam logic [WIDTH-1:0] WALK0 = WIDTH'(1) << (K % WIDTH);

    logic [31:0] lfsr;
    logic [31:0] lfsr_nxt;

    assign lfsr_nxt = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LSEED;
            data <= '0;
        end else if (load) begin
            lfsr <= LSEED;
            case (mode_new)
                2'd0:    data <= LSEED[WIDTH-1:0];
                2'd1:    data <= INC0;
                2'd2:    data <= WALK0;
                default: data <= '0;
            endcase
        end else if (adv) begin
            lfsr <= lfsr_nxt;
            case (mode_cur)
                2'd0:    data <= lfsr_nxt[WIDTH-1:0];
                2'd1:    data <= data + WIDTH'(1);
                // rotate left by one; degenerates to a no-op when WIDTH=1
                2'd2:    data <= (data << 1) | (data >> (WIDTH - 1));
                default: data <= '0;
            endcase
        end
    end
endmodule

module stim_gen #(
    parameter int          WIDTH      = 8,
    parameter int          CHANNELS   = 2,
    parameter int          NUM_CYCLES = 8,
    parameter logic [31:0] SEED       = 32'hACE1_2468,
    localparam int         CW         = (NUM_CYCLES > 1) ? $clog2(NUM_CYCLES) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic                      hold,
    output logic [CHANNELS*WIDTH-1:0] data,
    output logic                      valid,
    output logic [CW-1:0]             sample_idx,
    output logic                      busy,
    output logic                      done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CW-1:0] LAST = CW'(NUM_CYCLES - 1);

    state_t                             state, state_nxt;
    logic                               load, adv;
    logic [1:0]                         mode_q;
    logic [CW-1:0]                      idx;
    logic [CHANNELS-1:0][WIDTH-1:0]     lane_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mode_q <= 2'd0;
            idx    <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                mode_q <= mode;
                idx    <= '0;
            end else if (adv) begin
                idx <= idx + CW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        adv       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!hold) begin
                    // last sample: leave data in place for DONE/IDLE
                    if (idx == LAST) state_nxt = DONE;
                    else             adv       = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        stim_lane #(
            .WIDTH (WIDTH),
            .K     (k),
            .SEED  (SEED)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .load     (load),
            .adv      (adv),
            .mode_new (mode),
            .mode_cur (mode_q),
            .data     (lane_data[k])
        );
    end

    assign data       = lane_data;
    assign sample_idx = idx;
    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign valid      = (state == RUN) && !hold;
endmodule

// File: tb/tb_stim_gen.sv
`timescale 1ns/1ps
// tb_stim_gen: randomized bench for stim_gen. The default instance is driven
// through runs of every mode with random stalls, random start/mode noise and a
// mid-run asynchronous reset; a second instance covers NUM_CYCLES=1.
module tb_stim_gen;
    localparam int W = 8;
    localparam int C = 2;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst, start, hold;
    logic [1:0]     mode;
    logic [C*W-1:0] data;
    logic           valid, busy, done;
    logic [2:0]     sidx;

    logic           start1, hold1;
    logic [1:0]     mode1;
    logic [11:0]    data1;
    logic           valid1, busy1, done1;
    logic [0:0]     sidx1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [C*W-1:0] obs [N];
    logic [C*W-1:0] ref0 [N];

    stim_gen u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .hold(hold),
        .data(data), .valid(valid), .sample_idx(sidx), .busy(busy), .done(done)
    );

    stim_gen #(.WIDTH(4), .CHANNELS(3), .NUM_CYCLES(1)) u_one (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1), .hold(hold1),
        .data(data1), .valid(valid1), .sample_idx(sidx1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // reference pattern model, straight from the pattern rules
    function automatic logic [31:0] lstep(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [31:0] lseed(input int k);
        logic [31:0] r;
        r = 32'hACE1_2468 ^ (32'(k) * 32'h9E37_79B9);
        return (r == 32'd0) ? 32'd1 : r;
    endfunction

    function automatic logic [W-1:0] exp_ch(input int m, input int i, input int k);
        logic [31:0] s;
        case (m)
            0: begin
                s = lseed(k);
                for (int j = 0; j < i; j++) s = lstep(s);
                return s[W-1:0];
            end
            1:       return W'(k + i);
            2:       return W'(1) << ((i + k) % W);
            default: return '0;
        endcase
    endfunction

    function automatic logic [C*W-1:0] exp_bus(input int m, input int i);
        logic [C*W-1:0] b;
        for (int k = 0; k < C; k++) b[k*W +: W] = exp_ch(m, i, k);
        return b;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Entered #1 after an edge with the DUT in IDLE; returns likewise in IDLE.
    // hsel: 0 no stalls, 1 random stalls, 2 three stalls at sample 2.
    task automatic do_run(input int m, input int hsel, input bit keep);
        int i, hc, nv, cyc;
        bit h;
        start = 1'b1;
        mode  = 2'(m);
        tick();
        if (!keep) start = 1'b0;
        i = 0; hc = 0; nv = 0; cyc = 0;
        while (i < N && cyc < 200) begin
            case (hsel)
                1:       h = ($urandom_range(3) == 0);
                2:       h = (i == 2 && hc < 3);
                default: h = 1'b0;
            endcase
            if (h) hc++;
            hold = h;
            mode = 2'($urandom);
            if (!keep) start = 1'($urandom);
            #1;
            chk("run_valid", valid, !h);
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk("run_idx", sidx, i);
            chk($sformatf("run_data_m%0d_i%0d", m, i), data, exp_bus(m, i));
            if (valid) nv++;
            obs[i] = data;
            tick();
            cyc++;
            if (!h) i++;
        end
        chk("run_end", i, N);
        hold = 1'($urandom);
        mode = 2'($urandom);
        if (!keep) start = 1'($urandom);
        #1;
        chk("done_pulse", done, 1);
        chk("done_valid", valid, 0);
        chk("done_busy", busy, 0);
        chk("done_data", data, exp_bus(m, N - 1));
        chk("done_idx", sidx, N - 1);
        chk("n_valid", nv, N);
        tick();
        start = keep;
        hold  = 1'($urandom);
        #1;
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_valid", valid, 0);
        chk("idle_data", data, exp_bus(m, N - 1));
        hold = 1'b0;
    endtask

    task automatic one_run(input int m, input logic [11:0] want);
        start1 = 1'b1;
        mode1  = 2'(m);
        tick();
        start1 = 1'b0;
        hold1  = 1'b1;
        #1;
        chk("one_hold_valid", valid1, 0);
        chk("one_hold_busy", busy1, 1);
        tick();
        hold1 = 1'b0;
        #1;
        chk("one_valid", valid1, 1);
        chk("one_idx", sidx1, 0);
        chk($sformatf("one_data_m%0d", m), data1, want);
        tick();
        chk("one_done", done1, 1);
        chk("one_done_valid", valid1, 0);
        chk("one_done_data", data1, want);
        tick();
        chk("one_idle", done1 | busy1, 0);
    endtask

    initial begin
        bit differ;
        logic [31:0] s;
        logic [11:0] w0;
        rst = 1'b1; start = 1'b0; hold = 1'b0; mode = 2'd0;
        start1 = 1'b0; hold1 = 1'b0; mode1 = 2'd0;
        repeat (2) tick();
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", sidx, 0);
        chk("rst_data", data, 0);
        rst = 1'b0;

        do_run(1, 0, 1'b0);
        do_run(2, 0, 1'b0);
        do_run(1, 2, 1'b0);

        do_run(0, 0, 1'b0);
        for (int i = 0; i < N; i++) ref0[i] = obs[i];
        do_run(0, 0, 1'b0);
        differ = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("m0_repeat_%0d", i), obs[i], ref0[i]);
            if (obs[i][W-1:0] != obs[i][2*W-1:W]) differ = 1'b1;
        end
        chk("m0_ch_differ", differ, 1);

        do_run(3, 0, 1'b1);
        do_run(3, 1, 1'b1);
        start = 1'b0;

        // asynchronous reset in the middle of a run
        start = 1'b1; mode = 2'd1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("pre_rst_idx", sidx, 4);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_idx", sidx, 0);
        chk("arst_data", data, 0);
        #2 rst = 1'b0;
        tick();
        do_run(1, 0, 1'b0);
        do_run(0, 1, 1'b0);

        repeat (12) do_run(int'($urandom_range(3)), 1, 1'($urandom));
        start = 1'b0;

        one_run(1, 12'h210);
        one_run(2, 12'h421);
        for (int k = 0; k < 3; k++) begin
            s = lseed(k);
            w0[k*4 +: 4] = s[3:0];
        end
        one_run(0, w0);
        one_run(3, 12'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
